seg7_byte_decoder: RTL and testbench

//  Receive side of the 7-segment digit interface driven by hex_display.

---
 rtl/seg7_byte_decoder.sv | 115 +++++++++++
 tb/tb_seg7_byte_decoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_byte_decoder.sv
// Receive side of the 7-segment digit link: decodes active-low segment codes
// back to nibbles, pairs them into bytes, and flags and counts undecodable codes.
module seg7_byte_decoder #(
    parameter int LOW_FIRST = 0,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [6:0]           seg_in,
    input  logic                 seg_valid,
    output logic                 seg_ready,
    output logic [7:0]           byte_out,
    output logic                 byte_valid,
    input  logic                 byte_ready,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic                 clear
);

    // state  | meaning
    // FIRST  | waiting for the first digit of a pair
    // SECOND | first nibble latched, waiting for the second digit
    // HOLD   | byte presented on byte_out until downstream consumes it
    typedef enum logic [1:0] {
        FIRST  = 2'd0,
        SECOND = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [3:0] nib;
    logic       code_ok;
    logic [3:0] first_nib;
    logic       take;
    logic       take_ok;
    logic       take_bad;
    logic [7:0] byte_formed;

    always_comb begin
        nib     = 4'h0;
        code_ok = 1'b1;
        case (seg_in)
            7'b1000000: nib = 4'h0;
            7'b1111001: nib = 4'h1;
            7'b0100100: nib = 4'h2;
            7'b0110000: nib = 4'h3;
            7'b0011001: nib = 4'h4;
            7'b0010010: nib = 4'h5;
            7'b0000010: nib = 4'h6;
            7'b1111000: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0011000: nib = 4'h9;
            7'b0001000: nib = 4'hA;
            7'b0000011: nib = 4'hB;
            7'b1000110: nib = 4'hC;
            7'b0100001: nib = 4'hD;
            7'b0000110: nib = 4'hE;
            7'b0001110: nib = 4'hF;
            default:    code_ok = 1'b0;
        endcase
    end

    assign seg_ready   = (state != HOLD);
    assign byte_valid  = (state == HOLD);
    assign take        = seg_valid & seg_ready & ~clear;
    assign take_ok     = take & code_ok;
    assign take_bad    = take & ~code_ok;
    assign byte_formed = (LOW_FIRST != 0) ? {nib, first_nib} : {first_nib, nib};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= FIRST;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = FIRST;
        end else begin
            case (state)
                FIRST: begin
                    if (take_ok) state_nxt = SECOND;
                end
                SECOND: begin
                    if (take_ok)       state_nxt = HOLD;
                    else if (take_bad) state_nxt = FIRST;
                end
                HOLD: begin
                    if (byte_ready) state_nxt = FIRST;
                end
                default: state_nxt = FIRST;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            first_nib <= 4'h0;
            byte_out  <= 8'h00;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            err <= take_bad;
            if (clear) begin
                err_count <= '0;
            end else if (take_bad && (err_count != '1)) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
            if (take_ok && state == FIRST)  first_nib <= nib;
            if (take_ok && state == SECOND) byte_out  <= byte_formed;
        end
    end

endmodule

// File: tb/tb_seg7_byte_decoder.sv
// Randomized and directed bench for seg7_byte_decoder; both byte orders run
// side by side against a digit-pairing reference model.
module tb_seg7_byte_decoder;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [6:0] seg_in = 7'h7f;
    logic       seg_valid = 1'b0;
    logic       byte_ready = 1'b0;
    logic       clear = 1'b0;

    logic [1:0] sr, bv, er;
    logic [7:0] bo [2];
    logic [7:0] ec [2];

    int n_chk = 0;
    int n_bad = 0;

    logic [6:0] codes [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // reference model state, index 0 = high nibble first, 1 = low nibble first
    int         m_cnt  [2];
    logic [3:0] m_nib  [2][2];
    bit         m_hold [2];
    logic [7:0] m_byte [2];
    int         m_errc [2];
    bit         m_err  [2];

    always #5 clock = ~clock;

    seg7_byte_decoder #(.LOW_FIRST(0), .ERR_CNT_W(8)) u_hi (
        .clock(clock), .resetn(resetn), .seg_in(seg_in), .seg_valid(seg_valid),
        .seg_ready(sr[0]), .byte_out(bo[0]), .byte_valid(bv[0]),
        .byte_ready(byte_ready), .err(er[0]), .err_count(ec[0]), .clear(clear));

    seg7_byte_decoder #(.LOW_FIRST(1), .ERR_CNT_W(8)) u_lo (
        .clock(clock), .resetn(resetn), .seg_in(seg_in), .seg_valid(seg_valid),
        .seg_ready(sr[1]), .byte_out(bo[1]), .byte_valid(bv[1]),
        .byte_ready(byte_ready), .err(er[1]), .err_count(ec[1]), .clear(clear));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int lookup(input logic [6:0] code);
        for (int k = 0; k < 16; k++) if (codes[k] == code) return k;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_hold[i] = 0; m_byte[i] = 8'h00; m_errc[i] = 0; m_err[i] = 0;
        end
    endtask

    task automatic model_update();
        int idx;
        for (int i = 0; i < 2; i++) begin
            m_err[i] = 0;
            if (clear) begin
                m_cnt[i] = 0; m_hold[i] = 0; m_errc[i] = 0;
            end else if (m_hold[i]) begin
                if (byte_ready) m_hold[i] = 0;
            end else if (seg_valid) begin
                idx = lookup(seg_in);
                if (idx >= 0) begin
                    m_nib[i][m_cnt[i]] = idx[3:0];
                    m_cnt[i]++;
                    if (m_cnt[i] == 2) begin
                        m_byte[i] = (i == 1) ? {m_nib[i][1], m_nib[i][0]}
                                             : {m_nib[i][0], m_nib[i][1]};
                        m_hold[i] = 1;
                        m_cnt[i]  = 0;
                    end
                end else begin
                    m_cnt[i] = 0;
                    m_err[i] = 1;
                    if (m_errc[i] < 255) m_errc[i]++;
                end
            end
        end
    endtask

    task automatic compare();
        for (int i = 0; i < 2; i++) begin
            check(i ? "lo_seg_ready" : "hi_seg_ready", 32'(sr[i]), 32'(!m_hold[i]));
            check(i ? "lo_byte_valid" : "hi_byte_valid", 32'(bv[i]), 32'(m_hold[i]));
            check(i ? "lo_err" : "hi_err", 32'(er[i]), 32'(m_err[i]));
            check(i ? "lo_err_count" : "hi_err_count", 32'(ec[i]), 32'(m_errc[i]));
            if (m_hold[i]) check(i ? "lo_byte_out" : "hi_byte_out", 32'(bo[i]), 32'(m_byte[i]));
        end
    endtask

    // inputs are set before the call; the model sees the same values as the edge
    task automatic step();
        model_update();
        @(posedge clock);
        #1;
        compare();
    endtask

    task automatic do_reset();
        seg_valid = 1'b0; clear = 1'b0;
        resetn = 1'b0;
        #2;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            check("rst_seg_ready", 32'(sr[i]), 32'd1);
            check("rst_byte_valid", 32'(bv[i]), 32'd0);
            check("rst_err", 32'(er[i]), 32'd0);
            check("rst_err_count", 32'(ec[i]), 32'd0);
            check("rst_byte_out", 32'(bo[i]), 32'h00);
        end
        @(negedge clock);
        resetn = 1'b1;
        step();
    endtask

    task automatic send(input logic [6:0] code);
        seg_in = code; seg_valid = 1'b1;
        step();
        seg_valid = 1'b0; seg_in = 7'($urandom);
    endtask

    initial begin
        model_reset();
        @(posedge clock); #1;
        do_reset();

        // T1
        byte_ready = 1'b1;
        send(7'b0011001);
        send(7'b0010010);
        check("t1_byte_valid", 32'(bv[0]), 32'd1);
        check("t1_byte", 32'(bo[0]), 32'h45);
        step();
        check("t1_valid_one_cycle", 32'(bv[0]), 32'd0);
        check("t1_err_count", 32'(ec[0]), 32'd0);

        // T2
        byte_ready = 1'b0;
        send(7'b0001110);
        send(7'b0000011);
        for (int k = 0; k < 5; k++) begin
            check("t2_byte", 32'(bo[0]), 32'hFB);
            check("t2_seg_ready", 32'(sr[0]), 32'd0);
            seg_valid = 1'b1; seg_in = codes[3];
            step();
        end
        seg_valid = 1'b0;
        byte_ready = 1'b1;
        step();
        check("t2_released", 32'(bv[0]), 32'd0);

        // T3
        send(7'b1000000);
        send(7'b0111111);
        check("t3_err", 32'(er[0]), 32'd1);
        send(7'b1111001);
        check("t3_err_pulse", 32'(er[0]), 32'd0);
        send(7'b0100100);
        check("t3_err_count", 32'(ec[0]), 32'd1);
        check("t3_byte", 32'(bo[0]), 32'h12);
        step();

        // T4
        send(7'b0000010);
        send(7'b1111000);
        check("t4_byte_lo", 32'(bo[1]), 32'h76);
        check("t4_byte_hi", 32'(bo[0]), 32'h67);
        step();

        // T5
        for (int k = 0; k < 300; k++) send(7'b0111111);
        check("t5_saturated", 32'(ec[0]), 32'd255);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("t5_cleared", 32'(ec[0]), 32'd0);

        // T6
        send(7'b0000000);
        #2;
        do_reset();
        send(7'b0011000);
        send(7'b0001000);
        check("t6_byte", 32'(bo[0]), 32'h9A);
        step();

        // clear discards a digit and an unconsumed byte
        byte_ready = 1'b0;
        send(codes[1]);
        send(codes[2]);
        clear = 1'b1; seg_valid = 1'b1; seg_in = codes[3];
        step();
        clear = 1'b0; seg_valid = 1'b0;
        check("clr_drop_byte", 32'(bv[0]), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            seg_valid  = ($urandom_range(0, 3) != 0);
            seg_in     = ($urandom_range(0, 3) != 0) ? codes[$urandom_range(0, 15)] : 7'($urandom);
            byte_ready = $urandom_range(0, 1) != 0;
            clear      = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #2;
                do_reset();
            end else begin
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
